// File: rtl/sram_tone_player.sv
// sram_tone_player
//   Walks a song stored in external async SRAM as 2-word note records and
//   drives a square-wave speaker. Record at word address A:
//     word A   : half-period in PERIOD_SCALE-clock units (0 = rest)
//     word A+1 : duration in TICK_DIV-clock ticks (0 = end of song)
//   Address arithmetic wraps modulo 2^18.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   start        : 1-cycle pulse, begin playing at base_addr (only in IDLE)
//   stop         : 1-cycle pulse, abort playback (wins over start)
//   base_addr    : word address of the first record, sampled on accepted start
//   sram_addr    : SRAM word address
//   sram_oe_n    : SRAM output enable, active low
//   sram_io      : SRAM read data
//   speaker      : square-wave audio output
//   busy         : high in every state except IDLE
//   done         : 1-cycle pulse when the terminator record is read
//   note_cnt     : notes completed since the last accepted start
//   state_dbg    : current FSM state (0 IDLE, 1 FETCH_P, 2 FETCH_D, 3 PLAY)
module sram_tone_player #(
  parameter int PERIOD_SCALE = 8,
  parameter int TICK_DIV     = 50000,
  parameter int SRAM_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [17:0] base_addr,
  output logic [17:0] sram_addr,
  output logic        sram_oe_n,
  input  logic [15:0] sram_io,
  output logic        speaker,
  output logic        busy,
  output logic        done,
  output logic [15:0] note_cnt,
  output logic [1:0]  state_dbg
);

  // One spare bit on the half-period counter keeps hp*PERIOD_SCALE exact
  // for every 16-bit hp, including non power-of-two scales.
  localparam int HW = 16 + $clog2(PERIOD_SCALE) + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  localparam logic [HW-1:0] PS        = HW'(PERIOD_SCALE);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SRAM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_P = 2'd1,
    FETCH_D = 2'd2,
    PLAY    = 2'd3
  } state_t;

  state_t        state;
  logic [17:0]   addr;      // address of the record being fetched/played
  logic [WW-1:0] wcnt;      // SRAM wait counter
  logic [15:0]   hp;
  logic [15:0]   dur;
  logic [PW-1:0] pre;       // tick prescaler
  logic [15:0]   tcnt;      // ticks elapsed in the current note
  logic [HW-1:0] hcnt;      // cycles elapsed in the current half-period
  logic [HW-1:0] half_lim;

  assign half_lim  = HW'(hp) * PS;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      wcnt      <= '0;
      hp        <= '0;
      dur       <= '0;
      pre       <= '0;
      tcnt      <= '0;
      hcnt      <= '0;
      sram_addr <= '0;
      sram_oe_n <= 1'b1;
      speaker   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      note_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort from any state; note_cnt is deliberately kept.
        state     <= IDLE;
        speaker   <= 1'b0;
        sram_oe_n <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr      <= base_addr;
              sram_addr <= base_addr;
              sram_oe_n <= 1'b0;
              note_cnt  <= '0;
              wcnt      <= '0;
              busy      <= 1'b1;
              state     <= FETCH_P;
            end
          end

          FETCH_P: begin
            if (wcnt == WAIT_LAST) begin
              hp        <= sram_io;
              sram_addr <= addr + 18'd1;
              wcnt      <= '0;
              state     <= FETCH_D;
            end else begin
              wcnt <= wcnt + WW'(1);
            end
          end

          FETCH_D: begin
            if (wcnt == WAIT_LAST) begin
              wcnt      <= '0;
              sram_oe_n <= 1'b1;
              if (sram_io == 16'd0) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                dur     <= sram_io;
                addr    <= addr + 18'd2;
                pre     <= '0;
                tcnt    <= '0;
                hcnt    <= '0;
                speaker <= 1'b0;
                state   <= PLAY;
              end
            end else begin
              wcnt <= wcnt + WW'(1);
            end
          end

          PLAY: begin
            if (pre == PRE_LAST && tcnt == dur - 16'd1) begin
              // addr already points at the next record.
              note_cnt  <= note_cnt + 16'd1;
              speaker   <= 1'b0;
              sram_addr <= addr;
              sram_oe_n <= 1'b0;
              wcnt      <= '0;
              state     <= FETCH_P;
            end else begin
              if (pre == PRE_LAST) begin
                pre  <= '0;
                tcnt <= tcnt + 16'd1;
              end else begin
                pre <= pre + PW'(1);
              end
              if (hp != 16'd0) begin
                if (hcnt == half_lim - HW'(1)) begin
                  hcnt    <= '0;
                  speaker <= ~speaker;
                end else begin
                  hcnt <= hcnt + HW'(1);
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_tone_player.sv
module tb_sram_tone_player;

  localparam int TICK = 10;
  localparam int PSC  = 2;
  localparam int WAIT = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [17:0] base_addr;
  logic [17:0] sram_addr;
  logic        sram_oe_n;
  logic [15:0] sram_io;
  logic        speaker;
  logic        busy;
  logic        done;
  logic [15:0] note_cnt;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_pass;

  // Trace entry per cycle: {note_cnt, done, busy, speaker, sram_oe_n, sram_addr}
  logic [37:0] exp_q[$];

  logic [15:0] mem [0:262143];

  sram_tone_player #(
    .PERIOD_SCALE(PSC),
    .TICK_DIV    (TICK),
    .SRAM_WAIT   (WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .base_addr(base_addr),
    .sram_addr(sram_addr),
    .sram_oe_n(sram_oe_n),
    .sram_io  (sram_io),
    .speaker  (speaker),
    .busy     (busy),
    .done     (done),
    .note_cnt (note_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / SRAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data appears one cycle after the address.
  always @(posedge clk) sram_io <= mem[sram_addr];

  // ---------------- reference model ----------------
  // Pushes the expected cycle-by-cycle trace of a whole song, starting with
  // the first FETCH_P cycle and ending one cycle after the done pulse.
  task automatic model_song(input logic [17:0] base);
    logic [17:0] a;
    logic [17:0] a1;
    logic [15:0] nc;
    logic [15:0] hpv;
    logic [15:0] duv;
    int          hpi;
    int          nt;
    logic        spk;
    a  = base;
    nc = 16'd0;
    for (int r = 0; r < 64; r++) begin
      a1  = a + 18'd1;
      hpv = mem[a];
      duv = mem[a1];
      for (int k = 0; k < WAIT; k++) exp_q.push_back({nc, 1'b0, 1'b1, 1'b0, 1'b0, a});
      for (int k = 0; k < WAIT; k++) exp_q.push_back({nc, 1'b0, 1'b1, 1'b0, 1'b0, a1});
      if (duv == 16'd0) begin
        exp_q.push_back({nc, 1'b1, 1'b0, 1'b0, 1'b1, 18'd0});
        exp_q.push_back({nc, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0});
        break;
      end
      hpi = int'(hpv);
      nt  = int'(duv) * TICK;
      for (int c = 0; c < nt; c++) begin
        spk = (hpi == 0) ? 1'b0 : (((c / (hpi * PSC)) % 2) == 1);
        exp_q.push_back({nc, 1'b0, 1'b1, spk, 1'b1, 18'd0});
      end
      nc = nc + 16'd1;
      a  = a + 18'd2;
    end
  endtask

  task automatic start_song(input logic [17:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    model_song(base);
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [37:0] obs;
    obs = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
    n_checks++;
    if (obs !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0} || state_dbg !== 2'd0) begin
      $display("FAIL reset: got %h state %0d, expected %h state 0", obs, state_dbg,
               {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0});
    end else n_pass++;
  endtask

  task automatic test_basic_note(input string name);
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    int          cyc;
    mem[18'h10] = 16'd3; mem[18'h11] = 16'd2; mem[18'h12] = 16'd0; mem[18'h13] = 16'd0;
    start_song(18'h10);
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL %s cyc %0d: got %h expected %h (mask %h)", name, cyc, obs, exp, mask);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (state_dbg !== 2'd0 || note_cnt !== 16'd1)
      $display("FAIL %s end: state %0d note_cnt %0d, expected 0 and 1", name, state_dbg, note_cnt);
    else n_pass++;
  endtask

  task automatic test_rest();
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    int          cyc;
    mem[18'h30] = 16'd0; mem[18'h31] = 16'd3; mem[18'h32] = 16'd0; mem[18'h33] = 16'd0;
    start_song(18'h30);
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL rest cyc %0d: got %h expected %h", cyc, obs, exp);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    int          cyc;
    mem[18'h3FFFF] = 16'd1; mem[18'h00000] = 16'd1;
    mem[18'h00001] = 16'd0; mem[18'h00002] = 16'd0;
    start_song(18'h3FFFF);
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL wrap cyc %0d: got %h expected %h", cyc, obs, exp);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    int          cyc;
    for (int n = 0; n < 3; n++) begin
      mem[18'h100 + 18'(2 * n)] = 16'($urandom_range(0, 5));
      mem[18'h101 + 18'(2 * n)] = 16'($urandom_range(1, 3));
    end
    mem[18'h106] = 16'd0; mem[18'h107] = 16'd0;
    start_song(18'h100);
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL b2b cyc %0d: got %h expected %h", cyc, obs, exp);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (note_cnt !== 16'd3)
      $display("FAIL b2b note_cnt: got %0d expected 3", note_cnt);
    else n_pass++;
  endtask

  task automatic test_stop();
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    logic        saw_done;
    mem[18'h20] = 16'd1; mem[18'h21] = 16'd2; mem[18'h22] = 16'd2;
    mem[18'h23] = 16'd3; mem[18'h24] = 16'd0; mem[18'h25] = 16'd0;
    start_song(18'h20);
    // First note (4 fetch + 20 play), second fetch (4), then 5 cycles into PLAY.
    for (int cyc = 0; cyc < 33; cyc++) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL stop_pre cyc %0d: got %h expected %h", cyc, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
    exp_q.delete();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({state_dbg, busy, speaker, sram_oe_n, done, note_cnt} !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1})
      $display("FAIL stop: state %0d busy %b spk %b oe_n %b done %b note_cnt %0d, expected 0 0 0 1 0 1",
               state_dbg, busy, speaker, sram_oe_n, done, note_cnt);
    else n_pass++;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (saw_done !== 1'b0)
      $display("FAIL stop_quiet: done/busy seen after stop = %b, expected 0", saw_done);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    logic [37:0] exp;
    logic [37:0] obs;
    logic [37:0] mask;
    int          cyc;
    mem[18'h50] = 16'd7; mem[18'h51] = 16'd1; mem[18'h52] = 16'd5; mem[18'h53] = 16'd1;
    start_song(18'h10);
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = exp[18] ? {20'hFFFFF, 18'h0} : {38{1'b1}};
      obs  = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
      n_checks++;
      if ((obs & mask) !== (exp & mask))
        $display("FAIL start_busy cyc %0d: got %h expected %h", cyc, obs, exp);
      else n_pass++;
      if (cyc == 1 || cyc == 10) begin
        start     = 1'b1;
        base_addr = 18'h50;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    // start and stop together in IDLE: stop wins.
    start     = 1'b1;
    stop      = 1'b1;
    base_addr = 18'h50;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({state_dbg, busy, sram_oe_n} !== {2'd0, 1'b0, 1'b1})
        $display("FAIL start_stop cyc %0d: state %0d busy %b oe_n %b, expected 0 0 1",
                 k, state_dbg, busy, sram_oe_n);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [37:0] obs;
    // Reset during FETCH_D.
    start_song(18'h10);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'd2) $display("FAIL rst_pre_fd: state %0d expected 2", state_dbg);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    obs = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
    n_checks++;
    if (obs !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0} || state_dbg !== 2'd0)
      $display("FAIL rst_fd: got %h state %0d expected %h state 0", obs, state_dbg,
               {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // Reset during PLAY while the speaker is high (cycle 10 of the song).
    start_song(18'h10);
    exp_q.delete();
    for (int k = 0; k < 10; k++) @(negedge clk);
    n_checks++;
    if (speaker !== 1'b1) $display("FAIL rst_pre_play: speaker %b expected 1", speaker);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    obs = {note_cnt, done, busy, speaker, sram_oe_n, sram_addr};
    n_checks++;
    if (obs !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0} || state_dbg !== 2'd0)
      $display("FAIL rst_play: got %h state %0d expected %h state 0", obs, state_dbg,
               {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd0});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    test_basic_note("replay");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();

    test_basic_note("basic");
    test_rest();
    test_wrap();
    test_back_to_back();
    test_stop();
    test_start_busy();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
